// File: rtl/i2s_rx_fifo.sv
// I2S / left-justified serial audio receiver: deserialises L/R slots into stereo
// frames and queues them in a show-ahead FIFO with a VALID/READY handshake.
module i2s_rx_fifo #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 6,
    parameter int JUSTIFY = 0,
    parameter int DEPTH   = 4,
    parameter int AW      = 2
) (
    input  logic             BIT_CK,
    input  logic             RESET,
    input  logic             LR_CK,
    input  logic             DIN,
    input  logic             READY,
    output logic             VALID,
    output logic [WIDTH-1:0] DATA_L,
    output logic [WIDTH-1:0] DATA_R,
    output logic [CNT_W-1:0] SLOT_LEN,
    output logic             OVERFLOW,
    output logic [AW:0]      LEVEL
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]      W_U     = WIDTH;
    localparam bit               I2S     = (JUSTIFY == 0);

    logic             lr_q;
    logic             synced;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] n_fin;
    logic [31:0]      n_ext;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] sh_fin;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] left_hold;
    logic             left_valid;
    logic             take;
    logic             edge_det;
    logic             commit;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW-1:0]    head_idx;
    logic [2*WIDTH-1:0] mem [DEPTH];

    assign edge_det = (LR_CK != lr_q);
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign take     = (32'(cnt) < W_U);
    assign shift_in = take ? {shift_reg[WIDTH-2:0], DIN} : shift_reg;

    // In I2S mode the bit sampled on the LR edge still belongs to the outgoing slot.
    assign sh_fin = I2S ? shift_in : shift_reg;
    assign n_fin  = I2S ? cnt_inc  : cnt;
    assign n_ext  = 32'(n_fin);
    assign word   = (n_ext >= W_U) ? sh_fin : (sh_fin << (W_U - n_ext));

    assign commit = edge_det & synced;
    assign push   = commit & lr_q & left_valid;

    assign LEVEL  = wr_ptr - rd_ptr;
    assign VALID  = (LEVEL != '0);
    assign full   = (LEVEL == (AW+1)'(DEPTH));
    assign pop    = VALID & READY;
    assign accept = push & (~full | pop);

    // When empty, present the most recently read slot rather than the stale write slot.
    assign head_idx         = VALID ? rd_ptr[AW-1:0] : rd_ptr[AW-1:0] - 1'b1;
    assign {DATA_L, DATA_R} = mem[head_idx];

    always_ff @(posedge BIT_CK) begin
        if (RESET) begin
            lr_q       <= 1'b0;
            synced     <= 1'b0;
            cnt        <= '0;
            shift_reg  <= '0;
            left_hold  <= '0;
            left_valid <= 1'b0;
            SLOT_LEN   <= '0;
            OVERFLOW   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            lr_q <= LR_CK;
            if (edge_det) begin
                synced <= 1'b1;
                if (I2S) begin
                    shift_reg <= '0;
                    cnt       <= '0;
                end else begin
                    shift_reg <= {{(WIDTH-1){1'b0}}, DIN};
                    cnt       <= CNT_W'(1);
                end
                if (synced) begin
                    SLOT_LEN <= n_fin;
                    if (!lr_q) begin
                        left_hold  <= word;
                        left_valid <= 1'b1;
                    end else begin
                        left_valid <= 1'b0;
                    end
                end
            end else begin
                shift_reg <= shift_in;
                cnt       <= cnt_inc;
            end

            if (accept) begin
                mem[wr_ptr[AW-1:0]] <= {left_hold, word};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (push && !accept) begin
                OVERFLOW <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Directed bench for i2s_rx_fifo: an I2S instance (CNT_W=6) and a left-justified
// instance (CNT_W=5) share one serial stream.
module tb_i2s_rx_fifo;

    logic        BIT_CK = 1'b0;
    logic        RESET  = 1'b1;
    logic        LR_CK  = 1'b0;
    logic        DIN    = 1'b0;
    logic        READY  = 1'b0;

    logic        valid0, ovf0, valid1, ovf1;
    logic [15:0] dl0, dr0, dl1, dr1;
    logic [5:0]  len0;
    logic [4:0]  len1;
    logic [2:0]  lvl0, lvl1;

    int n_tests = 0;
    int n_fail  = 0;
    bit lj       = 1'b0;
    bit prev_bit = 1'b0;

    i2s_rx_fifo #(.WIDTH(16), .CNT_W(6), .JUSTIFY(0), .DEPTH(4), .AW(2)) dut0 (
        .BIT_CK(BIT_CK), .RESET(RESET), .LR_CK(LR_CK), .DIN(DIN), .READY(READY),
        .VALID(valid0), .DATA_L(dl0), .DATA_R(dr0), .SLOT_LEN(len0),
        .OVERFLOW(ovf0), .LEVEL(lvl0)
    );

    i2s_rx_fifo #(.WIDTH(16), .CNT_W(5), .JUSTIFY(1), .DEPTH(4), .AW(2)) dut1 (
        .BIT_CK(BIT_CK), .RESET(RESET), .LR_CK(LR_CK), .DIN(DIN), .READY(READY),
        .VALID(valid1), .DATA_L(dl1), .DATA_R(dr1), .SLOT_LEN(len1),
        .OVERFLOW(ovf1), .LEVEL(lvl1)
    );

    always #5 BIT_CK = ~BIT_CK;

    typedef struct {
        bit          lj;
        int          n;
        logic [31:0] l, r;
        logic [31:0] el0, er0, len0;
        int          m1;        // 0: skip dut1, 1: slot length only, 2: data and length
        logic [31:0] el1, er1, len1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at negedge, return 1 ns after the following posedge. In I2S format the
    // line carries the intended bit one BIT_CK late.
    task automatic drive_bit(input logic lr, input logic b);
        @(negedge BIT_CK);
        LR_CK = lr;
        DIN   = lj ? b : prev_bit;
        prev_bit = b;
        @(posedge BIT_CK);
        #1;
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) drive_bit(lr, data[i]);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        READY = 1'b0;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        RESET = 1'b0;
        prev_bit = 1'b0;
    endtask

    task automatic preamble();
        repeat (4) drive_bit(1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] l6, r6, k;
        logic [31:0] drain_ids [4];

        vecs[0] = '{0, 16, 32'hA5C3,     32'h1234,     32'hA5C3, 32'h1234, 16, 0, 0, 0, 0};
        vecs[1] = '{0, 32, 32'hBEEF0000, 32'h0F0F1111, 32'hBEEF, 32'h0F0F, 32, 1, 0, 0, 31};
        vecs[2] = '{0, 12, 32'hABC,      32'h123,      32'hABC0, 32'h1230, 12, 0, 0, 0, 0};
        vecs[3] = '{1, 16, 32'h8001,     32'h7FFE,     32'h0002, 32'hFFFC, 16, 2, 32'h8001, 32'h7FFE, 16};
        vecs[4] = '{0, 1,  32'h1,        32'h1,        32'h8000, 32'h8000, 1, 0, 0, 0, 0};
        vecs[5] = '{0, 17, 32'h1FFFF,    32'h00001,    32'hFFFF, 32'h0000, 17, 0, 0, 0, 0};

        do_reset();
        chk("rst_valid",    32'(valid0), 0);
        chk("rst_level",    32'(lvl0),   0);
        chk("rst_overflow", 32'(ovf0),   0);
        chk("rst_slot_len", 32'(len0),   0);
        chk("rst_data_l",   32'(dl0),    0);
        chk("rst_data_r",   32'(dr0),    0);
        chk("rst_valid1",   32'(valid1), 0);

        for (int i = 0; i < 6; i++) begin
            lj = vecs[i].lj;
            do_reset();
            preamble();
            send_slot(1'b0, vecs[i].l, vecs[i].n);
            send_slot(1'b1, vecs[i].r, vecs[i].n);
            drive_bit(1'b0, 1'b0);
            chk($sformatf("v%0d_valid", i),    32'(valid0), 1);
            chk($sformatf("v%0d_level", i),    32'(lvl0),   1);
            chk($sformatf("v%0d_data_l", i),   32'(dl0),    vecs[i].el0);
            chk($sformatf("v%0d_data_r", i),   32'(dr0),    vecs[i].er0);
            chk($sformatf("v%0d_slot_len", i), 32'(len0),   vecs[i].len0);
            if (vecs[i].m1 >= 1) chk($sformatf("v%0d_slot_len1", i), 32'(len1), vecs[i].len1);
            if (vecs[i].m1 == 2) begin
                chk($sformatf("v%0d_data_l1", i), 32'(dl1), vecs[i].el1);
                chk($sformatf("v%0d_data_r1", i), 32'(dr1), vecs[i].er1);
            end
            READY = 1'b1;
            drive_bit(1'b0, 1'b0);
            READY = 1'b0;
            chk($sformatf("v%0d_valid_after_pop", i), 32'(valid0), 0);
            chk($sformatf("v%0d_hold_data_l", i),     32'(dl0),    vecs[i].el0);
        end

        // Overflow: five frames into a 4-deep FIFO, then a push coinciding with a pop.
        lj = 1'b0;
        do_reset();
        preamble();
        for (int f = 1; f <= 5; f++) begin
            k = 32'(f);
            send_slot(1'b0, 32'h1000 + k, 16);
            send_slot(1'b1, 32'h2000 + k, 16);
        end
        l6 = 32'h1006;
        r6 = 32'h2006;
        drive_bit(1'b0, l6[15]);
        chk("ovf_level",    32'(lvl0), 4);
        chk("ovf_flag",     32'(ovf0), 1);
        chk("ovf_head_l",   32'(dl0),  32'h1001);
        chk("ovf_head_r",   32'(dr0),  32'h2001);
        for (int i = 14; i >= 0; i--) drive_bit(1'b0, l6[i]);
        send_slot(1'b1, r6, 16);
        READY = 1'b1;
        drive_bit(1'b0, 1'b0);
        READY = 1'b0;
        chk("pushpop_level", 32'(lvl0), 4);
        chk("pushpop_head",  32'(dl0),  32'h1002);
        chk("pushpop_ovf",   32'(ovf0), 1);
        drain_ids = '{2, 3, 4, 6};
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain%0d_valid", j),  32'(valid0), 1);
            chk($sformatf("drain%0d_data_l", j), 32'(dl0),    32'h1000 + drain_ids[j]);
            chk($sformatf("drain%0d_data_r", j), 32'(dr0),    32'h2000 + drain_ids[j]);
            READY = 1'b1;
            drive_bit(1'b0, 1'b0);
            READY = 1'b0;
        end
        chk("drained_level", 32'(lvl0), 0);
        chk("drained_valid", 32'(valid0), 0);
        READY = 1'b1;
        drive_bit(1'b0, 1'b0);
        READY = 1'b0;
        chk("empty_ready_level", 32'(lvl0), 0);
        chk("empty_hold_l",      32'(dl0),  32'h1006);

        // Reset in the middle of a right slot with two frames queued.
        do_reset();
        preamble();
        send_slot(1'b0, 32'h1111, 16);
        send_slot(1'b1, 32'h2222, 16);
        send_slot(1'b0, 32'h3333, 16);
        send_slot(1'b1, 32'h4444, 16);
        send_slot(1'b0, 32'h5555, 16);
        chk("pre_rst_level", 32'(lvl0), 2);
        for (int i = 15; i >= 8; i--) drive_bit(1'b1, 1'b1);
        RESET = 1'b1;
        drive_bit(1'b1, 1'b0);
        chk("mid_rst_valid",    32'(valid0), 0);
        chk("mid_rst_level",    32'(lvl0),   0);
        chk("mid_rst_overflow", 32'(ovf0),   0);
        RESET = 1'b0;
        repeat (7) drive_bit(1'b1, 1'b1);
        send_slot(1'b0, 32'hCAFE, 16);
        send_slot(1'b1, 32'hF00D, 16);
        drive_bit(1'b0, 1'b0);
        chk("post_rst_level",  32'(lvl0), 1);
        chk("post_rst_data_l", 32'(dl0),  32'hCAFE);
        chk("post_rst_data_r", 32'(dr0),  32'hF00D);
        chk("post_rst_len",    32'(len0), 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
